// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux arbiter: index-width helper and
// output-register state encoding.
package rr_mux_pkg;

    // Index width for n channels; never below 1 so a single channel still
    // yields a legal (always-zero) select field.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [SW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = SW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel round-robin mux with a registered valid/ready output stage.
// Optional packet lock (in_last port) enabled by defining RR_MUX_LOCK_EN.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]  in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]  in_last,
`endif
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_sel,
    input  logic          out_ready
);

    logic          out_valid_d, out_valid_q;
    logic [W-1:0]  out_data_d,  out_data_q;
    logic [SW-1:0] out_sel_d,   out_sel_q;
    logic [SW-1:0] ptr_d,       ptr_q;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_idx;
    logic          any;
    logic          load;
    logic          xfer;
    logic [SW-1:0] ptr_next;

`ifdef RR_MUX_LOCK_EN
    logic lock_d, lock_q;

    // While locked only the channel held in ptr may compete.
    always_comb begin
        req = in_valid;
        if (lock_q) begin
            req = in_valid & (N'(1) << ptr_q);
        end
    end
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = (out_valid_q == ST_EMPTY) || out_ready;
    assign xfer     = load && any;
    assign in_ready = xfer ? gnt : '0;
    assign ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
        lock_d      = lock_q;
`endif
        if (xfer) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    out_data_d = in_data[i*W +: W];
                end
            end
            out_sel_d   = gnt_idx;
            out_valid_d = ST_FULL;
`ifdef RR_MUX_LOCK_EN
            if ((in_last & gnt) == '0) begin
                lock_d = 1'b1;
                ptr_d  = gnt_idx;
            end else begin
                lock_d = 1'b0;
                ptr_d  = ptr_next;
            end
`else
            ptr_d       = ptr_next;
`endif
        end else if (out_ready) begin
            // Drained with nothing to refill; data/sel keep their last value.
            out_valid_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= ST_EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8); lock sequence runs only
// when RR_MUX_LOCK_EN is defined.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_sel;
    logic          out_ready;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]  in_last;
`endif

    int checks;
    int errors;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [SW-1:0] s,
                             input logic [W-1:0] d);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, "_sel"},   32'(out_sel),   32'(s));
        check_eq({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        in_last   = 4'b1111;
`endif

        // Reset with all channels requesting
        tick();
        tick();
        check_out("rst", 1'b0, 2'd0, 8'h00);
        check_eq("rst_in_ready", 32'(in_ready), 32'(4'b0001));
        rst_n = 1'b1;

        // Fairness: 0,1,2,3,0 back-to-back
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("fair%0d", i), 1'b1, SW'(i % 4), 8'(8'hA0 + (i % 4)));
        end
        // ptr=1; drain with nothing valid
        in_valid = 4'b0000;
        #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'(4'b0000));
        tick();
        check_out("drain", 1'b0, 2'd0, 8'hA0);

        // Bring ptr to 2 via ch1, then skip/wrap between ch1 and ch3
        in_valid = 4'b0010;
        tick();
        check_out("pre_skip", 1'b1, 2'd1, 8'hA1);
        in_valid = 4'b1010;
        #1;
        check_eq("skip_rdy0", 32'(in_ready), 32'(4'b1000));
        tick();
        check_out("skip0", 1'b1, 2'd3, 8'hA3);
        check_eq("skip_rdy1", 32'(in_ready), 32'(4'b0010));
        tick();
        check_out("skip1", 1'b1, 2'd1, 8'hA1);
        check_eq("skip_rdy2", 32'(in_ready), 32'(4'b1000));
        tick();
        check_out("skip2", 1'b1, 2'd3, 8'hA3);

        // ptr=0; load A2 from ch2 then stall 3 cycles
        in_valid = 4'b0100;
        tick();
        check_out("bp_load", 1'b1, 2'd2, 8'hA2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'(4'b0000));
            tick();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 2'd2, 8'hA2);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", 32'(in_ready), 32'(4'b1000));
        tick();
        check_out("bp_release", 1'b1, 2'd3, 8'hA3);

        // ptr=0; grant ch2 (ptr->3), then idle 5 cycles
        in_valid = 4'b0100;
        tick();
        check_out("idle_load", 1'b1, 2'd2, 8'hA2);
        in_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 1'b0, 2'd2, 8'hA2);
        end
        in_valid = 4'b1001;
        #1;
        check_eq("idle_resume_rdy", 32'(in_ready), 32'(4'b1000));
        tick();
        check_out("idle_resume", 1'b1, 2'd3, 8'hA3);

        // Asynchronous reset while holding a word
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 2'd0, 8'h00);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;

`ifdef RR_MUX_LOCK_EN
        // ptr=0: ch0 word moves ptr to 1, then ch1 holds the lock for 3 words
        in_valid = 4'b0001;
        tick();
        check_out("lk_pre", 1'b1, 2'd0, 8'hA0);
        in_valid = 4'b1111;
        in_last  = 4'b1101;
        tick();
        check_out("lk0", 1'b1, 2'd1, 8'hA1);
        tick();
        check_out("lk1", 1'b1, 2'd1, 8'hA1);
        in_last = 4'b1111;
        tick();
        check_out("lk2", 1'b1, 2'd1, 8'hA1);
        tick();
        check_out("lk_next", 1'b1, 2'd2, 8'hA2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised successor to the 2:1 bit mux: selects one of N W-bit input channels per cycle with round-robin arbitration instead of an external select.
- Registers the result behind a valid/ready handshake.
- Sits between multiple producer stages (register-file read ports, ALU/load results) and a single shared consumer in the miniCPU datapath.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (1..64).
- SW, $clog2(N), width of channel index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i at [i*W +: W].
- in_ready  output  N  one-hot acceptance; in_ready[i] high means channel i transfers this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered selected data.
- out_sel  output  SW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset is asynchronous on rst_n low. It clears out_valid=0, out_data=0, out_sel=0 and round-robin pointer ptr=0. in_ready is combinational and reads 0 while out is full and stalled.
- Two states, carried by out_valid:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = !out_valid || out_ready. The output register can accept a new word this cycle.
- Arbitration (combinational): search channels ptr, ptr+1, …, N-1, 0, …, ptr-1. The first channel with in_valid=1 is grant g. If no channel is valid, there is no grant.
- in_ready = onehot(g) when load && any in_valid; otherwise all zero. At most one bit is high.
- Transfer on edge when in_ready[g]=1:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1.
- Drain without refill (out_valid && out_ready && no in_valid): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): all registers hold, in_ready=0, ptr holds.
- Simultaneous drain and refill: back-to-back, full throughput of 1 word/cycle with no bubble.
- Latency: 1 cycle from input transfer to out_valid.
- ptr only advances on a transfer. An idle cycle never moves the pointer.
- With N=1, the block degenerates to a registered pipeline stage with out_sel=0.
- Producers must hold in_valid/in_data until their own in_ready; the arbiter may grant a different channel meanwhile.
- Reset asserted mid-transfer drops the held word. No partial state survives.

Optional Feature:
- Macro RR_MUX_LOCK_EN.
- When defined, adds input port in_last (N bits). After channel g transfers with in_last[g]=0, arbitration is locked to g: ptr is not advanced and other channels are ignored. The lock releases after the transfer with in_last[g]=1, at which point ptr <= g+1 mod N. The lock is cleared by reset.
- When undefined, no in_last port exists and every transfer rotates ptr as above.

Decomposition:
- Package rr_mux_pkg holds:
  - a clog2 helper function.
  - localparams for state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1).
- Sub-module rr_arbiter (N parameter; inputs req[N], ptr[SW]; outputs gnt[N] one-hot, gnt_idx[SW], any). It is purely combinational and is instantiated once.
- The top level owns the registers, ptr and the optional lock.

Test Plan:
- Reset: rst_n=0 with all in_valid=1 → out_valid=0, out_sel=0, out_data=0; then release, with ptr=0 first grant to channel 0.
- Fairness: N=4, W=8, in_valid=4'b1111 held, data ch i=8'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0, no bubbles.
- Skip and wrap: only ch1 and ch3 valid, ptr=2 → grant ch3, then ch1 (wrap), then ch3; ch0/ch2 in_ready stay 0.
- Backpressure: out full with 8'hA2, out_ready=0 for 3 cycles → in_ready=0000, out_data stays A2, ptr unchanged; out_ready=1 → next grant follows from ptr=3.
- Idle: all in_valid=0 for 5 cycles after a grant to ch2 → out_valid falls after drain, ptr stays 3; next request from ch0 and ch3 together → ch3 granted.
- RR_MUX_LOCK_EN: ch1 sends 3 words with in_last=0,0,1 while ch0, ch2, ch3 are valid → out_sel 1,1,1 then 2.
